// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: owns the register-file write port (WE3/A3/WD3) in W.
// Ports: clk/rst_n; pipeline W write (RegWrite_W, WriteReg_W, Result_W,
// npc_W, Jal_W); mult/div result in (md_valid/md_addr/md_data, md_ready);
// stall_req to hazard unit; rs_D/rt_D -> pend_rs/pend_rt; WE3/A3/WD3 out.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite_W,
    input  logic [4:0]  WriteReg_W,
    input  logic [31:0] Result_W,
    input  logic [31:0] npc_W,
    input  logic        Jal_W,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        stall_req,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    output logic        pend_rs,
    output logic        pend_rt,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] L_FULL  = CW'(DEPTH);
    localparam logic [SW-1:0] L_SMAX  = SW'(STARVE_MAX);
    localparam logic [PW-1:0] L_PLAST = PW'(DEPTH - 1);

    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_FORCE  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [DEPTH-1:0] r_valid;
    logic [SW-1:0] r_starve;
    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_live;
    logic [31:0] w_wd_pipe;
    logic [4:0]  w_head_addr;
    logic [31:0] w_head_data;
    logic        w_force_nxt;
    logic        w_hit_rs;
    logic        w_hit_rt;

    function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
        return (p == L_PLAST) ? '0 : p + 1'b1;
    endfunction

    assign w_empty     = (r_count == '0);
    assign w_live      = RegWrite_W && (WriteReg_W != 5'd0);
    assign w_wd_pipe   = Jal_W ? npc_W : Result_W;
    assign w_head_addr = r_addr[r_rptr];
    assign w_head_data = r_data[r_rptr];

    // Full blocks pushes even when a pop frees a slot this cycle.
    assign md_ready  = rst_n && (r_count < L_FULL);
    assign w_push    = md_valid && md_ready;
    assign stall_req = (r_state == S_FORCE);

    // In FORCE the W stage is frozen, so the pipeline request is ignored.
    always_comb begin
        w_pop = 1'b0;
        WE3   = 1'b0;
        A3    = 5'd0;
        WD3   = 32'd0;
        if (rst_n) begin
            if (r_state == S_FORCE) begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    WE3   = (w_head_addr != 5'd0);
                    A3    = w_head_addr;
                    WD3   = w_head_data;
                end
            end else if (w_live) begin
                WE3 = 1'b1;
                A3  = WriteReg_W;
                WD3 = w_wd_pipe;
            end else if (!w_empty) begin
                w_pop = 1'b1;
                WE3   = (w_head_addr != 5'd0);
                A3    = w_head_addr;
                WD3   = w_head_data;
            end
        end
    end

    // Valid bits are registered, so an entry pushed this cycle is not seen
    // while the entry being popped still is.
    always_comb begin
        w_hit_rs = 1'b0;
        w_hit_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == rs_D)) w_hit_rs = 1'b1;
            if (r_valid[i] && (r_addr[i] == rt_D)) w_hit_rt = 1'b1;
        end
    end

    assign pend_rs = rst_n && (rs_D != 5'd0) && w_hit_rs;
    assign pend_rt = rst_n && (rt_D != 5'd0) && w_hit_rt;

    assign w_force_nxt = (r_state == S_NORMAL) &&
                         (((r_count == L_FULL) && !w_pop) ||
                          (r_starve == L_SMAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_NORMAL;
            r_count  <= '0;
            r_rptr   <= '0;
            r_wptr   <= '0;
            r_valid  <= '0;
            r_starve <= '0;
        end else begin
            r_state <= w_force_nxt ? S_FORCE : S_NORMAL;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wptr <= f_nxt(r_wptr);
            if (w_pop)  r_rptr <= f_nxt(r_rptr);
            if (w_pop)  r_valid[r_rptr] <= 1'b0;
            if (w_push) r_valid[r_wptr] <= 1'b1;
            if (w_pop || w_empty)
                r_starve <= '0;
            else if ((r_state == S_NORMAL) && (r_starve != L_SMAX))
                r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= md_addr;
            r_data[r_wptr] <= md_data;
        end
    end

endmodule
